// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared state encoding, gap default and count clamp helper
package fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_GAP = 2;

    // Zero maps to zero_val, anything above max_val saturates at max_val.
    function automatic int unsigned clamp_count(
        input int unsigned value,
        input int unsigned zero_val,
        input int unsigned max_val
    );
        if (value == 0) begin
            return zero_val;
        end
        if (value > max_val) begin
            return max_val;
        end
        return value;
    endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// rtl/pattern_shift_reg.sv - captured pattern with a down-counting bit index
module pattern_shift_reg #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             reload,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             bit_next,
    output logic             last
);

    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shifted;

    // Next pattern/index: load captures fresh inputs, reload restarts the
    // stored pattern, shift walks the index down and holds it at zero.
    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        idx_d = idx_q;
        if (load) begin
            pat_d = pattern;
            len_d = len;
            idx_d = len - LEN_W'(1);
        end else if (reload) begin
            idx_d = len_q - LEN_W'(1);
        end else if (shift && (idx_q != '0)) begin
            idx_d = idx_q - LEN_W'(1);
        end
    end

    // The bit the index will point at after this edge, so the caller can
    // register it straight into its output flop.
    always_comb begin
        shifted  = pat_d >> idx_d;
        bit_next = shifted[0];
        last     = (idx_q == '0);
    end

    // Pattern, length and index storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else begin
            pat_q <= pat_d;
            len_q <= len_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter, optional FSM_GAP_EN inter-repetition gap
module seq_pattern_tx
    import fsm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4,
    parameter int GAP   = DEFAULT_GAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned REP_MAX = (1 << REP_W) - 1;

    if ((GAP < 0) || ((1 << LEN_W) <= WIDTH)) begin : g_bad_params
        $error("seq_pattern_tx: LEN_W must hold WIDTH and GAP must be non-negative");
    end

    state_e           state_q, state_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] len_c;
    logic [REP_W-1:0] reps_c;
    logic             sr_load, sr_shift, sr_reload;
    logic             sr_bit_next, sr_last;

`ifdef FSM_GAP_EN
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    // Clamp length and repetitions before they are captured.
    always_comb begin
        len_c  = LEN_W'(clamp_count(32'(len), WIDTH, WIDTH));
        reps_c = REP_W'(clamp_count(32'(reps), 1, REP_MAX));
    end

    pattern_shift_reg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shift_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (sr_load),
        .shift    (sr_shift),
        .reload   (sr_reload),
        .pattern  (pattern),
        .len      (len_c),
        .bit_next (sr_bit_next),
        .last     (sr_last)
    );

    // Next-state and registered output values; rep_q counts repetitions
    // still to go after the current one.
    always_comb begin
        state_d   = state_q;
        rep_d     = rep_q;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_reload = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
`ifdef FSM_GAP_EN
        gap_d     = gap_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sr_load = 1'b1;
                    rep_d   = reps_c - REP_W'(1);
                    state_d = ST_SHIFT;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                busy_d = 1'b1;
                if (!sr_last) begin
                    sr_shift = 1'b1;
                    valid_d  = 1'b1;
                end else if (rep_q != '0) begin
                    rep_d     = rep_q - REP_W'(1);
                    sr_reload = 1'b1;
`ifdef FSM_GAP_EN
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_W'(GAP - 1);
                    end else begin
                        valid_d = 1'b1;
                    end
`else
                    valid_d = 1'b1;
`endif
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
`ifdef FSM_GAP_EN
            ST_GAP: begin
                busy_d = 1'b1;
                if (gap_q == '0) begin
                    state_d = ST_SHIFT;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        out_d = valid_d & sr_bit_next;
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rep_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FSM_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FSM_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int REP_W = 4;
    localparam int GAP   = 2;
`ifdef FSM_GAP_EN
    localparam int GAP_M = GAP;
`else
    localparam int GAP_M = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] reps;
    logic             out;
    logic             valid;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];

    logic det_prev, det_out;

    seq_pattern_tx #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W),
        .REP_W (REP_W),
        .GAP   (GAP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .out     (out),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Two-ones detector fed from the serial output, registered result.
    always @(posedge clk) begin
        if (reset) begin
            det_prev <= 1'b0;
            det_out  <= 1'b0;
        end else begin
            det_prev <= valid & out;
            det_out  <= valid & out & det_prev;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Expected per-cycle {valid,out} stream built from the transfer rules.
    task automatic build_exp(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        int eff_l;
        int eff_r;
        eff_l = (l == 0 || l > WIDTH) ? WIDTH : int'(l);
        eff_r = (r == 0) ? 1 : int'(r);
        exp_q.delete();
        for (int rr = 0; rr < eff_r; rr++) begin
            for (int i = eff_l - 1; i >= 0; i--) exp_q.push_back({1'b1, p[i]});
            if (rr < eff_r - 1)
                for (int g = 0; g < GAP_M; g++) exp_q.push_back(2'b00);
        end
    endtask

    task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        pattern = p;
        len     = l;
        reps    = r;
        start   = 1'b1;
    endtask

    // Follows one transfer from the cycle after start through the done cycle.
    task automatic stream_check(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                                input bit mess, output logic [127:0] got, output int nbits);
        build_exp(p, l, r);
        got   = '0;
        nbits = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            chk("valid", valid, exp_q[k][1]);
            chk("out",   out,   exp_q[k][0]);
            chk("busy",  busy,  1'b1);
            chk("done_low", done, 1'b0);
            if (valid) begin
                got = {got[126:0], out};
                nbits++;
            end
            if (k == 0) begin
                start = 1'b0;
                if (mess) begin
                    pattern = ~p;
                    len     = 4'd2;
                    reps    = 4'd7;
                end
            end
            if (mess && k == 2) start = 1'b1;
            if (mess && k == 3) start = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", done,  1'b1);
        chk("done_busy",  busy,  1'b0);
        chk("done_valid", valid, 1'b0);
        chk("done_out",   out,   1'b0);
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_done",  done,  1'b0);
        chk("idle_busy",  busy,  1'b0);
        chk("idle_valid", valid, 1'b0);
        chk("idle_out",   out,   1'b0);
    endtask

    typedef struct {
        logic [7:0]   p;
        logic [3:0]   l;
        logic [3:0]   r;
        bit           mess;
        logic [127:0] exp_bits;
        int           exp_n;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [127:0] got;
        int           nbits;
        logic [7:0]   rp;
        logic [3:0]   rl;
        logic [3:0]   rr;

        vecs[0] = '{8'hB5, 4'd8,  4'd1, 1'b0, 128'hB5,   8};
        vecs[1] = '{8'h06, 4'd3,  4'd3, 1'b0, 128'h1B6,  9};
        vecs[2] = '{8'hA5, 4'd0,  4'd0, 1'b0, 128'hA5,   8};
        vecs[3] = '{8'hF0, 4'd12, 4'd2, 1'b0, 128'hF0F0, 16};
        vecs[4] = '{8'h01, 4'd1,  4'd4, 1'b0, 128'hF,    4};
        vecs[5] = '{8'hC3, 4'd8,  4'd1, 1'b1, 128'hC3,   8};
        vecs[6] = '{8'h2D, 4'd6,  4'd2, 1'b0, 128'hB6D,  12};

        reset   = 1'b1;
        start   = 1'b1;
        pattern = 8'hFF;
        len     = 4'd0;
        reps    = 4'd0;

        repeat (2) begin
            @(negedge clk);
            chk("rst_out",   out,   1'b0);
            chk("rst_valid", valid, 1'b0);
            chk("rst_busy",  busy,  1'b0);
            chk("rst_done",  done,  1'b0);
        end
        reset = 1'b0;
        start = 1'b0;
        idle_check();

        foreach (vecs[i]) begin
            @(negedge clk);
            launch(vecs[i].p, vecs[i].l, vecs[i].r);
            stream_check(vecs[i].p, vecs[i].l, vecs[i].r, vecs[i].mess, got, nbits);
            chk($sformatf("vec%0d_bits", i), got, vecs[i].exp_bits);
            chk($sformatf("vec%0d_nbits", i), nbits, vecs[i].exp_n);
            idle_check();
        end

        // Back-to-back: start during the done cycle.
        @(negedge clk);
        launch(8'h06, 4'd3, 4'd1);
        stream_check(8'h06, 4'd3, 4'd1, 1'b0, got, nbits);
        chk("b2b_first_bits", got, 128'h6);
        launch(8'h81, 4'd8, 4'd1);
        stream_check(8'h81, 4'd8, 4'd1, 1'b0, got, nbits);
        chk("b2b_second_bits", got, 128'h81);
        idle_check();

        // Reset abort after the third bit.
        @(negedge clk);
        launch(8'hFF, 4'd8, 4'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_valid", valid, 1'b1);
            chk("abort_out",   out,   1'b1);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_out0",   out,   1'b0);
        chk("abort_valid0", valid, 1'b0);
        chk("abort_busy0",  busy,  1'b0);
        chk("abort_done0",  done,  1'b0);
        reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_done",  done,  1'b0);
            chk("abort_no_valid", valid, 1'b0);
        end

        // Detector loopback: stream 0,1,1.
        @(negedge clk);
        launch(8'h03, 4'd3, 4'd1);
        stream_check(8'h03, 4'd3, 4'd1, 1'b0, got, nbits);
        chk("loop_bits", got, 128'h3);
        chk("loop_detect", det_out, 1'b1);
        idle_check();
        chk("loop_detect_clear", det_out, 1'b0);

        // Randomized transfers against the stream model.
        for (int n = 0; n < 25; n++) begin
            rp = 8'($urandom);
            rl = 4'($urandom_range(0, 15));
            rr = 4'($urandom_range(0, 4));
            @(negedge clk);
            launch(rp, rl, rr);
            stream_check(rp, rl, rr, 1'b0, got, nbits);
            chk("rand_nbits", nbits,
                ((rl == 0 || rl > WIDTH) ? WIDTH : int'(rl)) * ((rr == 0) ? 1 : int'(rr)));
            idle_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
